// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST pattern-generation controller:
// session FSM states, LFSR/MISR polynomial and the Galois step function.
package bist_pkg;

    localparam int LFSR_W  = 8;
    localparam int CNT_W   = 16;
    localparam int FLUSH_W = 4;

    // x^8 + x^6 + x^5 + x + 1, identical to the MISR feedback
    localparam logic [LFSR_W-1:0] LFSR_MASK = 8'h63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], 1'b0} ^ (q[LFSR_W-1] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Galois LFSR pattern source; load takes priority over step.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = 8'h01
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_VAL;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (step_i) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST session controller: drives LFSR patterns into the CUT, sequences the
// MISR clear/enable and compares the final signature against a golden value.
module bist_tpg_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned        NUM_PATTERNS = 255,
    parameter logic [LFSR_W-1:0]  SEED         = 8'h01,
    parameter int unsigned        CUT_LATENCY  = 1,
    parameter logic [LFSR_W-1:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              use_seed,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic [LFSR_W-1:0] sig,
    output logic [LFSR_W-1:0] pattern,
    output logic              pat_valid,
    output logic              misr_clr,
    output logic              misr_en,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam logic [CNT_W-1:0]   LAST_PAT   = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(CUT_LATENCY - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       count_q;
    logic [FLUSH_W-1:0]     flush_q;
    logic [CUT_LATENCY-1:0] lat_q;
    logic [CUT_LATENCY-1:0] lat_d;
    logic [LFSR_W-1:0]      pattern_q;
    logic                   pat_valid_q;
    logic                   misr_clr_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;

    logic [LFSR_W-1:0]      lfsr_q;
    logic [LFSR_W-1:0]      seed_d;
    logic [LFSR_W-1:0]      lfsr_val_d;
    logic                   lfsr_load_d;
    logic                   lfsr_step_d;
    logic                   abort_hit;
    logic                   last_pat;

    assign abort_hit = abort && (state_q != ST_IDLE);
    assign last_pat  = (count_q == LAST_PAT);

    always_comb begin
        seed_d = use_seed ? seed_in : SEED;
        // an all-zero seed would lock the LFSR, fall back to the default
        if (seed_d == '0) begin
            seed_d = SEED;
        end

        lat_d = (lat_q << 1) | CUT_LATENCY'(pat_valid_q);

        lfsr_load_d = 1'b0;
        lfsr_val_d  = SEED;
        lfsr_step_d = 1'b0;
        if (abort_hit) begin
            lfsr_load_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_load_d = 1'b1;
                        lfsr_val_d  = seed_d;
                    end
                end
                ST_CLEAR: lfsr_step_d = 1'b1;
                ST_RUN:   lfsr_step_d = !last_pat;
                default:  lfsr_step_d = 1'b0;
            endcase
        end
    end

    bist_lfsr #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (lfsr_load_d),
        .load_val_i (lfsr_val_d),
        .step_i     (lfsr_step_d),
        .q_o        (lfsr_q)
    );

    // Outputs are registered so that each state's outputs are visible in the
    // same cycle the state is occupied; the CLEAR->RUN edge emits pattern 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            flush_q     <= '0;
            lat_q       <= '0;
            pattern_q   <= '0;
            pat_valid_q <= 1'b0;
            misr_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (abort_hit) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            flush_q     <= '0;
            lat_q       <= '0;
            pat_valid_q <= 1'b0;
            misr_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            lat_q      <= lat_d;
            misr_clr_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_CLEAR;
                        misr_clr_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        count_q    <= '0;
                    end
                end
                ST_CLEAR: begin
                    state_q     <= ST_RUN;
                    pattern_q   <= lfsr_q;
                    pat_valid_q <= 1'b1;
                    count_q     <= '0;
                end
                ST_RUN: begin
                    if (last_pat) begin
                        state_q     <= ST_FLUSH;
                        pat_valid_q <= 1'b0;
                        flush_q     <= '0;
                    end else begin
                        pattern_q <= lfsr_q;
                        count_q   <= count_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == LAST_FLUSH) begin
                        state_q <= ST_COMPARE;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    state_q <= ST_DONE;
                    pass_q  <= (sig == GOLDEN_SIG);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pattern   = pattern_q;
    assign pat_valid = pat_valid_q;
    assign misr_clr  = misr_clr_q;
    assign misr_en   = lat_q[CUT_LATENCY-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Directed self-checking bench for bist_tpg_ctrl (N=255, latency 1, golden A5).
module tb_bist_tpg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       use_seed = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] sig = 8'hA5;
    logic [7:0] pattern;
    logic       pat_valid, misr_clr, misr_en, busy, done, pass;

    int checks = 0;
    int errors = 0;

    // session observations
    int         pv_cnt, en_cnt, clr_cnt, en_bad, pat_bad, done_cyc;
    logic       c1_clr, c1_pv, c1_busy, c1_done, c1_pass;
    logic [7:0] last_pat;
    logic [7:0] seen [0:9];
    logic [7:0] exp_tab [0:9];

    bist_tpg_ctrl #(
        .NUM_PATTERNS (255),
        .SEED         (8'h01),
        .CUT_LATENCY  (1),
        .GOLDEN_SIG   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .use_seed  (use_seed),
        .seed_in   (seed_in),
        .sig       (sig),
        .pattern   (pattern),
        .pat_valid (pat_valid),
        .misr_clr  (misr_clr),
        .misr_en   (misr_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] tb_step(input logic [7:0] q);
        logic [7:0] n;
        n[0] = q[7];
        n[1] = q[0] ^ q[7];
        n[2] = q[1];
        n[3] = q[2];
        n[4] = q[3];
        n[5] = q[4] ^ q[7];
        n[6] = q[5] ^ q[7];
        n[7] = q[6];
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one session from a start pulse; cycle 1 is the cycle after the
    // start edge. pulse_at>0 re-pulses start during that cycle.
    task automatic run_session(input logic [7:0] first_exp, input int pulse_at);
        logic [7:0] model;
        logic       prev_pv;
        model    = first_exp;
        pv_cnt   = 0; en_cnt = 0; clr_cnt = 0; en_bad = 0; pat_bad = 0; done_cyc = 0;
        last_pat = 8'h00;
        for (int i = 0; i < 10; i++) seen[i] = 8'h00;
        start = 1'b1;
        tick();
        start   = 1'b0;
        c1_clr  = misr_clr;
        c1_pv   = pat_valid;
        c1_busy = busy;
        c1_done = done;
        c1_pass = pass;
        if (misr_clr) clr_cnt++;
        prev_pv = pat_valid;
        for (int c = 2; c <= 400 && done_cyc == 0; c++) begin
            start = (c - 1 == pulse_at);
            tick();
            start = 1'b0;
            if (misr_clr) clr_cnt++;
            if (misr_en !== prev_pv) en_bad++;
            if (misr_en) en_cnt++;
            if (pat_valid) begin
                if (pv_cnt < 10) seen[pv_cnt] = pattern;
                if (pattern !== model) pat_bad++;
                model    = tb_step(model);
                last_pat = pattern;
                pv_cnt++;
            end
            prev_pv = pat_valid;
            if (done) done_cyc = c;
        end
    endtask

    initial begin
        exp_tab[0] = 8'h01; exp_tab[1] = 8'h02; exp_tab[2] = 8'h04; exp_tab[3] = 8'h08;
        exp_tab[4] = 8'h10; exp_tab[5] = 8'h20; exp_tab[6] = 8'h40; exp_tab[7] = 8'h80;
        exp_tab[8] = 8'h63; exp_tab[9] = 8'hC6;

        // reset state
        #12;
        chk("rst_pattern", 32'(pattern), 0);
        chk("rst_outputs", 32'({pat_valid, misr_clr, misr_en, busy, done, pass}), 0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 0);

        // session 1: default seed, matching signature
        sig = 8'hA5;
        run_session(8'h01, 0);
        chk("s1_clr_cycle1", 32'(c1_clr), 1);
        chk("s1_pv_cycle1", 32'(c1_pv), 0);
        chk("s1_busy_cycle1", 32'(c1_busy), 1);
        for (int i = 0; i < 10; i++)
            chk($sformatf("s1_pattern%0d", i), 32'(seen[i]), 32'(exp_tab[i]));
        chk("s1_clr_count", 32'(clr_cnt), 1);
        chk("s1_pv_count", 32'(pv_cnt), 255);
        chk("s1_en_count", 32'(en_cnt), 255);
        chk("s1_en_delay", 32'(en_bad), 0);
        chk("s1_pattern_seq", 32'(pat_bad), 0);
        chk("s1_wrap_to_seed", 32'(tb_step(last_pat)), 32'h01);
        chk("s1_done_cycle", 32'(done_cyc), 259);
        chk("s1_pass", 32'(pass), 1);
        chk("s1_busy_done", 32'(busy), 0);
        tick();
        tick();
        chk("s1_done_hold", 32'({done, pass}), 32'b11);
        chk("s1_pattern_hold", 32'(pattern), 32'(last_pat));

        // session 2: mismatching signature, start re-pulsed during RUN
        sig = 8'hA4;
        run_session(8'h01, 10);
        chk("s2_done_drop", 32'({c1_done, c1_pass}), 0);
        chk("s2_pv_count", 32'(pv_cnt), 255);
        chk("s2_done_cycle", 32'(done_cyc), 259);
        chk("s2_done", 32'(done), 1);
        chk("s2_pass", 32'(pass), 0);

        // session 3: zero runtime seed falls back to default
        sig = 8'hA5;
        use_seed = 1'b1;
        seed_in  = 8'h00;
        run_session(8'h01, 0);
        chk("s3_first", 32'(seen[0]), 32'h01);
        chk("s3_pattern_seq", 32'(pat_bad), 0);

        // session 4: runtime seed 80
        seed_in = 8'h80;
        run_session(8'h80, 0);
        chk("s4_p0", 32'(seen[0]), 32'h80);
        chk("s4_p1", 32'(seen[1]), 32'h63);
        chk("s4_p2", 32'(seen[2]), 32'hC6);
        chk("s4_pattern_seq", 32'(pat_bad), 0);
        chk("s4_pass", 32'(pass), 1);
        use_seed = 1'b0;

        // abort 10 cycles into RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("ab_running", 32'({pat_valid, busy}), 32'b11);
        chk("ab_pattern10", 32'(pattern), 32'hC6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_outputs", 32'({busy, pat_valid, misr_en, done, misr_clr}), 0);
        tick();
        chk("ab_en_stays_low", 32'(misr_en), 0);
        run_session(8'h01, 0);
        chk("ab_restart_first", 32'(seen[0]), 32'h01);
        chk("ab_restart_pv", 32'(pv_cnt), 255);
        chk("ab_restart_done", 32'(done_cyc), 259);

        // async reset in FLUSH
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 256; i++) tick();
        chk("fl_in_flush", 32'({busy, pat_valid, done}), 32'b100);
        #2;
        rst = 1'b0;
        #1;
        chk("fl_rst_pattern", 32'(pattern), 0);
        chk("fl_rst_outputs", 32'({pat_valid, misr_clr, misr_en, busy, done, pass}), 0);
        #2;
        rst = 1'b1;
        tick();
        tick();
        chk("fl_idle", 32'({busy, done, pat_valid}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
